// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx byte transmitter among
// N_REQ requesters, with per-requester lock to keep multi-byte packets together.
module uart_tx_arbiter #(
   parameter int N_REQ         = 4,
   parameter int IDW           = 2,
   parameter int START_TIMEOUT = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [N_REQ-1:0]   REQ,
   input  logic [8*N_REQ-1:0] DATA_IN,
   input  logic [N_REQ-1:0]   LOCK,
   output logic [N_REQ-1:0]   ACK,
   output logic [IDW-1:0]     GRANT_ID,
   output logic               BUSY,
   output logic               ERR,
   output logic               TX_SEND,
   output logic [7:0]         TX_DATA,
   input  logic               TX_READY
);

   localparam int CW = $clog2(START_TIMEOUT) + 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWaitLow, StWaitHigh} stateT;

   stateT            stateQ, stateD;
   logic [IDW-1:0]   ptrQ, ptrD;
   logic             lockValidQ, lockValidD;
   logic [IDW-1:0]   lockOwnerQ, lockOwnerD;
   logic [CW-1:0]    cntQ, cntD;
   logic             txSendQ, txSendD;
   logic [7:0]       txDataQ, txDataD;
   logic [N_REQ-1:0] ackQ, ackD;
   logic [IDW-1:0]   grantIdQ, grantIdD;
   logic             busyQ, busyD;
   logic             errQ, errD;

   logic             lockHold;
   logic             found;
   logic [IDW-1:0]   winner;
   logic [IDW-1:0]   cand;
   logic [7:0]       winData;

   // Winner selection: a live lock owner wins outright, otherwise first set REQ after the pointer.
   always_comb begin
      lockHold = lockValidQ && REQ[lockOwnerQ] && LOCK[lockOwnerQ];
      found    = 1'b0;
      winner   = '0;
      cand     = '0;
      if (lockHold) begin
         found  = 1'b1;
         winner = lockOwnerQ;
      end else begin
         for (int off = 1; off <= N_REQ; off++) begin
            cand = IDW'((int'(ptrQ) + off) % N_REQ);
            if (!found && REQ[cand]) begin
               found  = 1'b1;
               winner = cand;
            end
         end
      end
      winData = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (winner == IDW'(i)) winData = DATA_IN[8*i +: 8];
      end
   end

   // Next-state and registered-output logic for the send sequencer.
   always_comb begin
      stateD     = stateQ;
      ptrD       = ptrQ;
      lockValidD = lockValidQ;
      lockOwnerD = lockOwnerQ;
      cntD       = cntQ;
      txSendD    = 1'b0;
      txDataD    = txDataQ;
      ackD       = '0;
      grantIdD   = grantIdQ;
      errD       = errQ;
      unique case (stateQ)
         StIdle: begin
            // Owner dropped REQ or LOCK: release now so round-robin runs this same cycle.
            if (lockValidQ && !lockHold) lockValidD = 1'b0;
            if (TX_READY && found) begin
               txDataD      = winData;
               grantIdD     = winner;
               ptrD         = winner;
               lockValidD   = LOCK[winner];
               lockOwnerD   = winner;
               txSendD      = 1'b1;
               ackD[winner] = 1'b1;
               stateD       = StIssue;
            end
         end
         StIssue: begin
            cntD   = '0;
            stateD = StWaitLow;
         end
         StWaitLow: begin
            if (!TX_READY) begin
               stateD = StWaitHigh;
            end else if (cntQ == CW'(START_TIMEOUT - 1)) begin
               errD       = 1'b1;
               lockValidD = 1'b0;
               stateD     = StIdle;
            end else begin
               cntD = cntQ + CW'(1);
            end
         end
         StWaitHigh: begin
            if (TX_READY) stateD = StIdle;
         end
         default: stateD = StIdle;
      endcase
      busyD = (stateD != StIdle);
   end

   // State and output registers; reset puts requester 0 first in line.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stateQ     <= StIdle;
         ptrQ       <= IDW'(N_REQ - 1);
         lockValidQ <= 1'b0;
         lockOwnerQ <= '0;
         cntQ       <= '0;
         txSendQ    <= 1'b0;
         txDataQ    <= '0;
         ackQ       <= '0;
         grantIdQ   <= '0;
         busyQ      <= 1'b0;
         errQ       <= 1'b0;
      end else begin
         stateQ     <= stateD;
         ptrQ       <= ptrD;
         lockValidQ <= lockValidD;
         lockOwnerQ <= lockOwnerD;
         cntQ       <= cntD;
         txSendQ    <= txSendD;
         txDataQ    <= txDataD;
         ackQ       <= ackD;
         grantIdQ   <= grantIdD;
         busyQ      <= busyD;
         errQ       <= errD;
      end
   end

   assign ACK      = ackQ;
   assign GRANT_ID = grantIdQ;
   assign BUSY     = busyQ;
   assign ERR      = errQ;
   assign TX_SEND  = txSendQ;
   assign TX_DATA  = txDataQ;

endmodule
